// File: rtl/tm_input_conditioner.sv
// ---------------------------------------------------------------------------
// tm_input_conditioner
//
// Front end of the Turing machine core. Turns the raw user controls into
// clean signals: the data switches and both buttons are synchronised, the
// buttons are debounced, the data word is frozen while a button is down,
// and every debounced button rise becomes a one-cycle pulse. It also counts
// the program words entered during the load phase and the steps requested
// afterwards.
//
// Parameters
//   DEBOUNCE  synchronised cycles a button level must hold before the
//             debounced output follows it (>= 1)
//   COUNT_W   width of word_count and step_count
//
// Ports
//   clock       in   single clock for all logic
//   reset       in   synchronous, active-high reset
//   raw_data    in   [3:0] asynchronous data switches
//   raw_next    in   asynchronous, bouncy Next button
//   raw_done    in   asynchronous, bouncy Done button
//   input_data  out  [3:0] data word, held constant while a button is down
//   Next        out  debounced Next level
//   Done        out  debounced Done level
//   next_pulse  out  one-cycle pulse after each debounced Next rise
//   done_pulse  out  one-cycle pulse after each debounced Done rise
//   load_phase  out  high from reset until the first Done press
//   word_count  out  [COUNT_W-1:0] Next presses seen in the load phase
//   step_count  out  [COUNT_W-1:0] Next presses seen after the load phase
// ---------------------------------------------------------------------------
module tm_input_conditioner #(
  parameter int DEBOUNCE = 4,
  parameter int COUNT_W  = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         raw_data,
  input  logic               raw_next,
  input  logic               raw_done,
  output logic [3:0]         input_data,
  output logic               Next,
  output logic               Done,
  output logic               next_pulse,
  output logic               done_pulse,
  output logic               load_phase,
  output logic [COUNT_W-1:0] word_count,
  output logic [COUNT_W-1:0] step_count
);

  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(DEBOUNCE - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic {
    PH_LOAD,
    PH_RUN
  } phase_t;

  logic [3:0]         r_dataS1;
  logic [3:0]         r_dataS2;
  logic               r_nextS1;
  logic               r_nextS2;
  logic               r_doneS1;
  logic               r_doneS2;
  logic [CNT_W-1:0]   r_nextCnt;
  logic [CNT_W-1:0]   r_doneCnt;
  logic               r_next;
  logic               r_done;
  logic               r_nextDly;
  logic               r_doneDly;
  logic               r_nextPulse;
  logic               r_donePulse;
  logic [3:0]         r_inputData;
  logic [COUNT_W-1:0] r_wordCount;
  logic [COUNT_W-1:0] r_stepCount;
  phase_t             r_phase;
  phase_t             w_phaseNext;

  // Two-flop synchronisers; nothing downstream ever looks at a raw input.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_dataS1 <= '0;
      r_dataS2 <= '0;
      r_nextS1 <= 1'b0;
      r_nextS2 <= 1'b0;
      r_doneS1 <= 1'b0;
      r_doneS2 <= 1'b0;
    end else begin
      r_dataS1 <= raw_data;
      r_dataS2 <= r_dataS1;
      r_nextS1 <= raw_next;
      r_nextS2 <= r_nextS1;
      r_doneS1 <= raw_done;
      r_doneS2 <= r_doneS1;
    end
  end

  // Next debouncer: the counter only advances while the synchronised level
  // disagrees with the debounced one, so any bounce back restarts it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_nextCnt <= '0;
      r_next    <= 1'b0;
    end else if (r_nextS2 == r_next) begin
      r_nextCnt <= '0;
    end else if (r_nextCnt == CNT_MAX) begin
      r_next    <= r_nextS2;
      r_nextCnt <= '0;
    end else begin
      r_nextCnt <= r_nextCnt + 1'b1;
    end
  end

  // Done debouncer, identical to the Next one.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_doneCnt <= '0;
      r_done    <= 1'b0;
    end else if (r_doneS2 == r_done) begin
      r_doneCnt <= '0;
    end else if (r_doneCnt == CNT_MAX) begin
      r_done    <= r_doneS2;
      r_doneCnt <= '0;
    end else begin
      r_doneCnt <= r_doneCnt + 1'b1;
    end
  end

  // Rise detection: the delayed copy lags the debounced level by one cycle,
  // so the pulse register is high for the single cycle after a 0->1 change.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_nextDly   <= 1'b0;
      r_doneDly   <= 1'b0;
      r_nextPulse <= 1'b0;
      r_donePulse <= 1'b0;
    end else begin
      r_nextDly   <= r_next;
      r_doneDly   <= r_done;
      r_nextPulse <= r_next & ~r_nextDly;
      r_donePulse <= r_done & ~r_doneDly;
    end
  end

  // Data word follows the synchronised switches only while both buttons are
  // up, so the core sees one constant word for the whole press.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_inputData <= '0;
    end else if (!r_next && !r_done) begin
      r_inputData <= r_dataS2;
    end
  end

  // Phase state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_phase <= PH_LOAD;
    end else begin
      r_phase <= w_phaseNext;
    end
  end

  // Phase next-state: the first Done press ends loading for good.
  always_comb begin
    w_phaseNext = r_phase;
    if (r_phase == PH_LOAD && r_donePulse) begin
      w_phaseNext = PH_RUN;
    end
  end

  // Press counters. Both look at the current phase, so a Next press landing
  // together with the Done that ends loading still counts as a program word.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wordCount <= '0;
      r_stepCount <= '0;
    end else if (r_nextPulse) begin
      if (r_phase == PH_LOAD) begin
        if (r_wordCount != COUNT_MAX) begin
          r_wordCount <= r_wordCount + 1'b1;
        end
      end else begin
        if (r_stepCount != COUNT_MAX) begin
          r_stepCount <= r_stepCount + 1'b1;
        end
      end
    end
  end

  assign input_data = r_inputData;
  assign Next       = r_next;
  assign Done       = r_done;
  assign next_pulse = r_nextPulse;
  assign done_pulse = r_donePulse;
  assign load_phase = (r_phase == PH_LOAD);
  assign word_count = r_wordCount;
  assign step_count = r_stepCount;

endmodule

// File: tb/tb_tm_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_tm_input_conditioner
//
// Self-checking bench for tm_input_conditioner. A cycle-by-cycle vector table
// covers reset, a clean Next press and the data freeze; hand-written
// sequences cover bounce rejection, the load/compute phase switch, counter
// saturation (second instance with COUNT_W=3), simultaneous Next/Done and a
// reset in the middle of a press.
// ---------------------------------------------------------------------------
module tb_tm_input_conditioner;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] raw_data;
  logic       raw_next;
  logic       raw_done;

  logic [3:0] input_data;
  logic       Next;
  logic       Done;
  logic       next_pulse;
  logic       done_pulse;
  logic       load_phase;
  logic [5:0] word_count;
  logic [5:0] step_count;

  logic [3:0] satInputData;
  logic       satNext;
  logic       satDone;
  logic       satNextPulse;
  logic       satDonePulse;
  logic       satLoadPhase;
  logic [2:0] satWordCount;
  logic [2:0] satStepCount;

  int applied    = 0;
  int miscompares = 0;
  int nextPulseSeen = 0;
  int donePulseSeen = 0;

  typedef struct {
    logic       rst;
    logic       nxt;
    logic       dn;
    logic [3:0] data;
    logic       expNext;
    logic       expPulse;
    logic       chkData;
    logic [3:0] expData;
    logic [5:0] expWord;
  } vec_t;

  vec_t vecs[$];

  always #5 clock = ~clock;

  tm_input_conditioner #(.DEBOUNCE(4), .COUNT_W(6)) dut (
    .clock      (clock),
    .reset      (reset),
    .raw_data   (raw_data),
    .raw_next   (raw_next),
    .raw_done   (raw_done),
    .input_data (input_data),
    .Next       (Next),
    .Done       (Done),
    .next_pulse (next_pulse),
    .done_pulse (done_pulse),
    .load_phase (load_phase),
    .word_count (word_count),
    .step_count (step_count)
  );

  tm_input_conditioner #(.DEBOUNCE(4), .COUNT_W(3)) dutSat (
    .clock      (clock),
    .reset      (reset),
    .raw_data   (raw_data),
    .raw_next   (raw_next),
    .raw_done   (raw_done),
    .input_data (satInputData),
    .Next       (satNext),
    .Done       (satDone),
    .next_pulse (satNextPulse),
    .done_pulse (satDonePulse),
    .load_phase (satLoadPhase),
    .word_count (satWordCount),
    .step_count (satStepCount)
  );

  // Pulses last one cycle, so each one is seen at exactly one falling edge.
  always @(negedge clock) begin
    if (next_pulse === 1'b1) nextPulseSeen++;
    if (done_pulse === 1'b1) donePulseSeen++;
  end

  function automatic void addVec(logic rst, logic nxt, logic dn, logic [3:0] data,
                                 logic eNext, logic ePulse, logic cData,
                                 logic [3:0] eData, logic [5:0] eWord);
    vec_t v;
    v.rst = rst; v.nxt = nxt; v.dn = dn; v.data = data;
    v.expNext = eNext; v.expPulse = ePulse; v.chkData = cData;
    v.expData = eData; v.expWord = eWord;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input logic rst, input logic nxt, input logic dn,
                               input logic [3:0] data);
    @(negedge clock);
    reset    = rst;
    raw_next = nxt;
    raw_done = dn;
    raw_data = data;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic stepEdge();
    @(posedge clock);
    #1;
  endtask

  // One full press of Next (isDone=0) or Done (isDone=1) with a long idle gap.
  task automatic pressButton(input bit isDone);
    @(negedge clock);
    if (isDone) raw_done = 1'b1; else raw_next = 1'b1;
    repeat (8) @(negedge clock);
    raw_done = 1'b0;
    raw_next = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  task automatic waitNextLevel(input logic level, input int maxCycles, input string name);
    bit found = 1'b0;
    for (int i = 0; i < maxCycles && !found; i++) begin
      @(negedge clock);
      if (Next === level) found = 1'b1;
    end
    applied++;
    if (!found) begin
      miscompares++;
      $display("[TB] FAIL %s: Next never reached %0d within %0d cycles", name, level, maxCycles);
    end
  endtask

  initial begin
    int pulseBase;
    int doneBase;
    reset    = 1'b1;
    raw_next = 1'b0;
    raw_done = 1'b0;
    raw_data = 4'd0;

    // Reset, data pass-through, a 10-cycle clean Next press starting before
    // edge 4 (Next high edges 9..18, pulse after edge 10, count at 11) and a
    // data change to 9 while the word is frozen at 3.
    addVec(1, 0, 0, 4'd3, 0, 0, 1, 4'd0, 6'd0);
    addVec(0, 0, 0, 4'd3, 0, 0, 1, 4'd0, 6'd0);
    addVec(0, 0, 0, 4'd3, 0, 0, 1, 4'd0, 6'd0);
    addVec(0, 0, 0, 4'd3, 0, 0, 1, 4'd3, 6'd0);
    for (int i = 0; i < 5; i++) addVec(0, 1, 0, 4'd3, 0, 0, 1, 4'd3, 6'd0);
    addVec(0, 1, 0, 4'd3, 1, 0, 1, 4'd3, 6'd0);
    addVec(0, 1, 0, 4'd9, 1, 1, 1, 4'd3, 6'd0);
    for (int i = 0; i < 3; i++) addVec(0, 1, 0, 4'd9, 1, 0, 1, 4'd3, 6'd1);
    for (int i = 0; i < 5; i++) addVec(0, 0, 0, 4'd9, 1, 0, 1, 4'd3, 6'd1);
    addVec(0, 0, 0, 4'd9, 0, 0, 1, 4'd3, 6'd1);
    addVec(0, 0, 0, 4'd9, 0, 0, 0, 4'd0, 6'd1);
    addVec(0, 0, 0, 4'd9, 0, 0, 0, 4'd0, 6'd1);
    addVec(0, 0, 0, 4'd9, 0, 0, 1, 4'd9, 6'd1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].nxt, vecs[i].dn, vecs[i].data);
      stepEdge();
      checkOutput($sformatf("vec%0d Next", i), Next, vecs[i].expNext);
      checkOutput($sformatf("vec%0d next_pulse", i), next_pulse, vecs[i].expPulse);
      checkOutput($sformatf("vec%0d word_count", i), word_count, vecs[i].expWord);
      checkOutput($sformatf("vec%0d load_phase", i), load_phase, 1);
      checkOutput($sformatf("vec%0d Done", i), Done, 0);
      if (vecs[i].chkData) checkOutput($sformatf("vec%0d input_data", i), input_data, vecs[i].expData);
    end
    checkOutput("clean press pulse count", nextPulseSeen, 1);

    // Bounce rejection: 1,0,1,0 then held high; Next must rise exactly five
    // edges after the final rise and only one pulse may appear.
    pulseBase = nextPulseSeen;
    @(negedge clock); raw_next = 1'b1;
    @(negedge clock); raw_next = 1'b0;
    @(negedge clock); raw_next = 1'b1;
    @(negedge clock); raw_next = 1'b0;
    @(negedge clock); raw_next = 1'b1;
    for (int i = 0; i < 5; i++) begin
      stepEdge();
      checkOutput($sformatf("bounce Next low edge+%0d", i), Next, 0);
    end
    stepEdge();
    checkOutput("bounce Next rise edge+5", Next, 1);
    repeat (3) @(negedge clock);
    raw_next = 1'b0;
    repeat (10) @(negedge clock);
    checkOutput("bounce pulse count", nextPulseSeen - pulseBase, 1);
    checkOutput("bounce word_count", word_count, 2);

    // Phase switch plus saturation in the COUNT_W=3 instance.
    repeat (25) pressButton(1'b0);
    checkOutput("load word_count", word_count, 27);
    checkOutput("load load_phase", load_phase, 1);
    checkOutput("load step_count", step_count, 0);
    checkOutput("sat word_count", satWordCount, 7);
    doneBase = donePulseSeen;
    pressButton(1'b1);
    checkOutput("done pulse count", donePulseSeen - doneBase, 1);
    checkOutput("after done load_phase", load_phase, 0);
    checkOutput("after done word_count", word_count, 27);
    repeat (5) pressButton(1'b0);
    checkOutput("run step_count", step_count, 5);
    checkOutput("run word_count", word_count, 27);
    pressButton(1'b1);
    checkOutput("second done load_phase", load_phase, 0);
    checkOutput("second done word_count", word_count, 27);
    checkOutput("second done step_count", step_count, 5);
    checkOutput("second done pulse count", donePulseSeen - doneBase, 2);
    checkOutput("sat step_count", satStepCount, 5);
    checkOutput("sat load_phase", satLoadPhase, 0);

    // Simultaneous Next and Done in the load phase.
    applyStimulus(1, 0, 0, 4'd0);
    applyStimulus(0, 0, 0, 4'd0);
    @(negedge clock);
    raw_next = 1'b1;
    raw_done = 1'b1;
    repeat (8) @(negedge clock);
    raw_next = 1'b0;
    raw_done = 1'b0;
    repeat (10) @(negedge clock);
    checkOutput("both word_count", word_count, 1);
    checkOutput("both step_count", step_count, 0);
    checkOutput("both load_phase", load_phase, 0);

    // Reset in the middle of a held Next press.
    @(negedge clock); raw_next = 1'b1;
    waitNextLevel(1'b1, 20, "pre-reset Next rise");
    repeat (3) @(negedge clock);
    reset = 1'b1;
    stepEdge();
    checkOutput("reset input_data", input_data, 0);
    checkOutput("reset Next", Next, 0);
    checkOutput("reset Done", Done, 0);
    checkOutput("reset next_pulse", next_pulse, 0);
    checkOutput("reset done_pulse", done_pulse, 0);
    checkOutput("reset load_phase", load_phase, 1);
    checkOutput("reset word_count", word_count, 0);
    checkOutput("reset step_count", step_count, 0);
    pulseBase = nextPulseSeen;
    @(negedge clock); reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      stepEdge();
      checkOutput($sformatf("re-press Next low edge+%0d", i), Next, 0);
    end
    stepEdge();
    checkOutput("re-press Next rise edge+5", Next, 1);
    repeat (4) @(negedge clock);
    checkOutput("re-press pulse count", nextPulseSeen - pulseBase, 1);
    checkOutput("re-press word_count", word_count, 1);
    checkOutput("re-press load_phase", load_phase, 1);
    raw_next = 1'b0;
    repeat (10) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/tm_input_conditioner.md
# tm_input_conditioner

Front-end stage that sits directly upstream of the Turing machine core. It cleans the raw user inputs (4-bit data switches and the Next/Done buttons) into stable, glitch-free signals. It synchronises and debounces the buttons, freezes the data word while a button is asserted, and emits single-cycle press pulses. It also tracks how many program words were entered in the load phase and how many steps were requested in the compute phase.

## Interface
Parameters:
- DEBOUNCE, 4: consecutive synchronised cycles a button level must hold before the output follows; legal range ≥1.
- COUNT_W, 6: width of word_count and step_count.

Ports:
- clock  input  1  single clock for all logic.
- reset  input  1  reset is synchronous and active-high.
- raw_data  input  4  asynchronous data switches.
- raw_next  input  1  asynchronous Next button, bouncy.
- raw_done  input  1  asynchronous Done button, bouncy.
- input_data  output  4  stable data word for the core.
- Next  output  1  debounced Next level for the core.
- Done  output  1  debounced Done level for the core.
- next_pulse  output  1  one-cycle pulse on each debounced Next rise.
- done_pulse  output  1  one-cycle pulse on each debounced Done rise.
- load_phase  output  1  1 from reset until the first debounced Done rise, then 0.
- word_count  output  COUNT_W  Next rises counted while load_phase=1, saturating.
- step_count  output  COUNT_W  Next rises counted while load_phase=0, saturating.

## Operation
- Synchronisers: raw_data, raw_next and raw_done each pass through 2 flops (s1→s2) before any other use.
- Debounce, per button, with its own counter cnt (width ⌈log2 DEBOUNCE⌉, minimum 1):
  - s2 == out: cnt←0.
  - s2 != out and cnt < DEBOUNCE-1: cnt←cnt+1.
  - s2 != out and cnt == DEBOUNCE-1: out←s2, cnt←0.
  - Any bounce back to out before the count completes restarts the count.
- Pulses: next_pulse = registered (Next rising this edge). It is high for exactly the one cycle after Next goes 0→1. There is no pulse on falling edges. done_pulse is identical for Done.
- Data hold:
  - While Next==0 and Done==0, input_data ← synchronised raw_data each cycle.
  - While either is 1, input_data holds its value, so the core sees a constant word for the whole press.
- Phase and counters:
  - next_pulse with load_phase=1: word_count++, saturating at 2^COUNT_W-1.
  - next_pulse with load_phase=0: step_count++, saturating at 2^COUNT_W-1.
  - done_pulse with load_phase=1: load_phase←0.
  - done_pulse with load_phase=0: ignored, apart from the pulse itself.
- Simultaneous next_pulse and done_pulse in the load phase: the word is counted into word_count (not step_count), and load_phase clears on the same edge.
- Reset (any cycle, including mid-debounce or mid-press):
  - Synchronisers, cnt, Next, Done, both pulses, input_data, word_count and step_count all go to 0; load_phase goes to 1.
  - A button still held after reset is re-debounced from 0 and produces a fresh pulse.

## Timing
- Button latency: if raw_next is high and stable before clock edge 0, s2 is 1 after edge 1. Next rises at edge DEBOUNCE+1 and next_pulse is high for the cycle following edge DEBOUNCE+2. With DEBOUNCE=4: Next rises at edge 5, pulse high from edge 6 to edge 7.
- Release latency equals press latency; no pulse on release.
- Glitches: a raw level held fewer than DEBOUNCE synchronised cycles never reaches Next, Done or the pulses.
- Data latency: 2 edges from raw_data to the synchronised value, plus 1 edge into input_data, so 3 edges total when not frozen.
- Freeze timing: the value captured at the last edge with Next=0 is the one held. raw_data changes during a press appear 3 edges after release completes.
- Counters and load_phase update on the edge that follows the pulse cycle. They are registered, not combinational from the pulse.
- Reset values: input_data=0, Next=0, Done=0, next_pulse=0, done_pulse=0, load_phase=1, word_count=0, step_count=0.

## Test plan
- Clean press: DEBOUNCE=4, raw_next high for 10 cycles → Next high exactly 10 cycles, starting 5 edges after the rise; next_pulse high for exactly one cycle; word_count=1.
- Bounce rejection: raw_next toggles 1,0,1,0 each cycle, then stays high → exactly one next_pulse, and Next rises only 5 edges after the final stable rise.
- Data freeze: raw_data=3, press Next, set raw_data=9 mid-press → input_data stays 3 until Next falls, then becomes 9 three edges later.
- Phase switch: 27 Next presses, then one Done press, then 5 Next presses → word_count=27, load_phase=0, step_count=5; a second Done press leaves load_phase=0 and the counts unchanged.
- Saturation: COUNT_W=3, 10 Next presses in the load phase → word_count=7.
- Reset mid-press: assert reset while Next=1 with raw_next held → all outputs at reset values the next cycle; after reset drops, Next re-rises after 5 edges with one new pulse and word_count=1.
